// File: rtl/tdes_pkg.sv
// Shared types and constants for the Triple-DES pass sequencer.
// The sequencer and its key selector both import this package.
package tdes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } seq_state_t;

    localparam logic ENCRYPT    = 1'b1;
    localparam int   NUM_PASSES = 3;

    typedef logic [1:0] pass_t;

    localparam pass_t LAST_PASS = pass_t'(NUM_PASSES - 1);

endpackage

// File: rtl/tdes_key_select.sv
// Pass schedule decode: picks the key and core direction for the current pass.
// Encrypt runs E(k1) D(k2) E(k3); decrypt runs D(k3) E(k2) D(k1).
module tdes_key_select
    import tdes_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  pass_t             pass,
    input  logic              mode,
    input  logic [DATA_W-1:0] key1,
    input  logic [DATA_W-1:0] key2,
    input  logic [DATA_W-1:0] key3,
    output logic [DATA_W-1:0] des_key,
    output logic              des_decrypt
);

    always_comb begin
        des_key     = key1;
        des_decrypt = 1'b0;
        case (pass)
            2'd0:    des_key = (mode == ENCRYPT) ? key1 : key3;
            2'd1:    des_key = key2;
            default: des_key = (mode == ENCRYPT) ? key3 : key1;
        endcase
        // The middle pass always runs the opposite direction to the outer two.
        des_decrypt = (pass == 2'd1) ? (mode == ENCRYPT) : (mode != ENCRYPT);
    end

endmodule

// File: rtl/tdes_sequencer.sv
// Triple-DES pass sequencer: runs a single-round-set DES core three times over a
// start/done handshake and hands the final block back to the AHB-Lite slave controller.
module tdes_sequencer
    import tdes_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 64
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic              encryption_type,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] key1,
    input  logic [DATA_W-1:0] key2,
    input  logic [DATA_W-1:0] key3,
    input  logic              des_done,
    input  logic [DATA_W-1:0] des_out,
    output logic              des_start,
    output logic              des_decrypt,
    output logic [DATA_W-1:0] des_key,
    output logic [DATA_W-1:0] des_in,
    output logic [DATA_W-1:0] output_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output seq_state_t        dbg_state
);

    localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);

    // Handshake with the core: des_start is a one-cycle launch while in RUN; des_done
    // is a one-cycle pulse carrying des_out and is only accepted while in WAIT.

    seq_state_t        state_q, state_d;
    pass_t             pass_q, pass_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] k1_q, k1_d;
    logic [DATA_W-1:0] k2_q, k2_d;
    logic [DATA_W-1:0] k3_q, k3_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              des_start_q, des_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [DATA_W-1:0] sel_key;
    logic              sel_decrypt;

    tdes_key_select #(
        .DATA_W (DATA_W)
    ) u_key_select (
        .pass        (pass_q),
        .mode        (mode_q),
        .key1        (k1_q),
        .key2        (k2_q),
        .key3        (k3_q),
        .des_key     (sel_key),
        .des_decrypt (sel_decrypt)
    );

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        timer_d = timer_q;
        mode_d  = mode_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
        work_d  = work_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, ERROR: begin
                if (start) begin
                    mode_d  = encryption_type;
                    k1_d    = key1;
                    k2_d    = key2;
                    k3_d    = key3;
                    work_d  = data;
                    pass_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (des_done) begin
                    work_d = des_out;
                    if (pass_q == LAST_PASS) begin
                        out_d   = des_out;
                        state_d = DONE;
                    end else begin
                        pass_d  = pass_t'(pass_q + 2'd1);
                        state_d = RUN;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    state_d = ERROR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        des_start_d = (state_d == RUN);
        busy_d      = (state_d == RUN) || (state_d == WAIT) || (state_d == DONE);
        error_d     = (state_d == ERROR);
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q     <= IDLE;
            pass_q      <= '0;
            timer_q     <= '0;
            mode_q      <= 1'b0;
            k1_q        <= '0;
            k2_q        <= '0;
            k3_q        <= '0;
            work_q      <= '0;
            out_q       <= '0;
            des_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            timer_q     <= timer_d;
            mode_q      <= mode_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            k3_q        <= k3_d;
            work_q      <= work_d;
            out_q       <= out_d;
            des_start_q <= des_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Key/direction only drive the core while a job is active, so the idle bus reads zero
    // even though the decrypt schedule would otherwise decode des_decrypt=1 at pass 0.
    assign des_key     = busy_q ? sel_key : '0;
    assign des_decrypt = busy_q & sel_decrypt;
    assign des_start   = des_start_q;
    assign des_in      = work_q;
    assign output_data = out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign dbg_state   = state_q;

endmodule
